fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction-fetch stage directly upstream of the control unit. Holds the PC and drives
//  the instruction-memory address. Registers each fetched word into the instruction port
//  the control unit decodes. Consumes the control unit's pcControl, branch outcome and
//  target, with a hardware return-address stack for CALL/RET. Taken redirect = 1 bubble.
// PARAMETERS
//  ADDR_W       16  PC / instruction-memory address width
//  STACK_DEPTH   8  return-address stack entries (power of 2, >=2)
//  RESET_PC      0  PC value loaded on reset
// PORTS
//  clock         in   1       single clock; all state on rising edge
//  reset         in   1       asynchronous, active-high; clears all state
//  stall         in   1       1 = freeze PC, IR, valid, stack; pc_control ignored
//  pc_control    in   3       from control unit: 0 INC,1 JUMP,2 BRANCH,3 CALL,4 RET,5 HLT,6/7=INC
//  branch_taken  in   1       condition result for BRANCH (from ALU flags)
//  jump_target   in   ADDR_W  target for JUMP/BRANCH/CALL
//  imem_addr     out  ADDR_W  = pc (combinational), read address to instruction ROM
//  imem_data     in   32      ROM word for imem_addr, valid same cycle
//  instruction   out  32      registered instruction to control unit
//  instr_valid   out  1       instruction holds a live (non-flushed) word
//  instr_pc      out  ADDR_W  address the current instruction was fetched from
//  halted        out  1       1 = HALT state reached; sticky until reset
//  stack_fault   out  1       1 = overflow/underflow detected; sticky until reset
//  stack_count   out  $clog2(STACK_DEPTH)+1  current stack occupancy
// BEHAVIOUR
//  Reset values: pc=RESET_PC, instruction=0, instr_valid=0, instr_pc=0, halted=0,
//   stack_fault=0, stack_count=0, state=RUN. Reset mid-operation aborts immediately.
//  States: RUN, HALT. RUN->HALT on accepted HLT, CALL overflow, or RET underflow.
//   HALT is terminal until reset.
//  Accept rule: pc_control is acted on only when state=RUN, instr_valid=1, stall=0.
//   It always refers to the word in instruction/instr_pc.
//  Each RUN edge with stall=0:
//   INC, or not accepted:  IR<=imem_data, instr_pc<=pc, valid<=1, pc<=pc+1.
//   JUMP:                  pc<=jump_target, valid<=0 (fetched word discarded).
//   BRANCH taken:          as JUMP.
//   BRANCH not taken:      as INC.
//   CALL:                  push instr_pc+1, then as JUMP.
//   RET:                   pop top -> pc, valid<=0.
//   HLT:                   state<=HALT, valid<=0, pc held.
//  Stall: all registers hold, imem_addr stable. Stall + redirect in the same cycle ->
//   stall wins; the same instruction re-presents its pc_control after stall drops.
//  HALT: instr_valid=0, pc/imem_addr frozen, stall and pc_control ignored.
//  Stack boundaries:
//   CALL with stack_count==STACK_DEPTH: no push, stack_fault<=1, HALT.
//   RET with stack_count==0: no pop, stack_fault<=1, HALT.
//  Arithmetic: pc+1 and instr_pc+1 wrap modulo 2**ADDR_W; no fault on wrap.
//  Latency: reset release -> first valid instruction after 1 edge. Taken redirect ->
//   target word valid 2 edges after acceptance (1 bubble).
// CONFIGURATION
//  FETCH_CALL_STACK_EN defined: return stack, CALL/RET, stack_fault, stack_count as above.
//  Undefined: no stack storage; CALL behaves as JUMP; RET behaves as HLT.
//   stack_fault and stack_count tied to 0.
// TESTING
//  1 Reset, ROM[i]=i, all pc_control INC -> instr_pc 0,1,2,3 on successive edges.
//    instr_valid=1 from edge 1.
//  2 At instr_pc=2, JUMP target 0x40 -> next edge valid=0; following edge
//    instr_pc=0x40, pc=0x41.
//  3 BRANCH at pc 5, target 0x10: taken=0 -> instr_pc 6; taken=1 -> bubble then 0x10.
//  4 CALL at 0x03 to 0x20, RET at 0x21 -> stack_count 1 then 0; execution resumes
//    at instr_pc=0x04.
//  5 STACK_DEPTH=2, three nested CALLs -> 3rd sets stack_fault=1 and halted=1;
//    RET on empty stack after reset -> same faults.
//  6 Stall held 3 cycles during JUMP -> pc/IR frozen, redirect taken after release.
//    Reset asserted mid-stall -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, registered instruction word and redirect handling.
// Define FETCH_CALL_STACK_EN to build the CALL/RET return-address stack.
module fetch_unit #(
    parameter int                ADDR_W      = 16,
    parameter int                STACK_DEPTH = 8,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         stall,
    input  logic [2:0]                   pc_control,
    input  logic                         branch_taken,
    input  logic [ADDR_W-1:0]            jump_target,
    output logic [ADDR_W-1:0]            imem_addr,
    input  logic [31:0]                  imem_data,
    output logic [31:0]                  instruction,
    output logic                         instr_valid,
    output logic [ADDR_W-1:0]            instr_pc,
    output logic                         halted,
    output logic                         stack_fault,
    output logic [$clog2(STACK_DEPTH):0] stack_count
);

    localparam logic [2:0] OP_JUMP   = 3'd1;
    localparam logic [2:0] OP_BRANCH = 3'd2;
    localparam logic [2:0] OP_CALL   = 3'd3;
    localparam logic [2:0] OP_RET    = 3'd4;
    localparam logic [2:0] OP_HLT    = 3'd5;

    typedef enum logic {RUN, HALT} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [31:0]         ir_q, ir_d;
    logic [ADDR_W-1:0]   ipc_q, ipc_d;
    logic                valid_q, valid_d;
    logic                redirect;
    logic                stop;
    logic [ADDR_W-1:0]   redirPc;

`ifdef FETCH_CALL_STACK_EN
    localparam int CNT_W = $clog2(STACK_DEPTH) + 1;
    localparam int PTR_W = $clog2(STACK_DEPTH);

    logic [ADDR_W-1:0]   stack_q [STACK_DEPTH];
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                fault_q, fault_d;
    logic                push;
    logic [PTR_W-1:0]    topPtr;

    assign topPtr = PTR_W'(cnt_q - CNT_W'(1));
`endif

    // pc_control always describes the word currently held in the instruction register.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        ipc_d    = ipc_q;
        valid_d  = valid_q;
        redirect = 1'b0;
        stop     = 1'b0;
        redirPc  = jump_target;
`ifdef FETCH_CALL_STACK_EN
        cnt_d    = cnt_q;
        fault_d  = fault_q;
        push     = 1'b0;
`endif
        if (state_q == RUN && !stall) begin
            ir_d    = imem_data;
            ipc_d   = pc_q;
            valid_d = 1'b1;
            pc_d    = pc_q + ADDR_W'(1);
            if (valid_q) begin
                case (pc_control)
                    OP_JUMP:   redirect = 1'b1;
                    OP_BRANCH: redirect = branch_taken;
`ifdef FETCH_CALL_STACK_EN
                    OP_CALL: begin
                        if (cnt_q == CNT_W'(STACK_DEPTH)) begin
                            stop    = 1'b1;
                            fault_d = 1'b1;
                        end else begin
                            push     = 1'b1;
                            cnt_d    = cnt_q + CNT_W'(1);
                            redirect = 1'b1;
                        end
                    end
                    OP_RET: begin
                        if (cnt_q == '0) begin
                            stop    = 1'b1;
                            fault_d = 1'b1;
                        end else begin
                            cnt_d    = cnt_q - CNT_W'(1);
                            redirect = 1'b1;
                            redirPc  = stack_q[topPtr];
                        end
                    end
`else
                    OP_CALL:   redirect = 1'b1;
                    OP_RET:    stop = 1'b1;
`endif
                    OP_HLT:    stop = 1'b1;
                    default:   ;
                endcase
            end
            // A redirect throws away the word fetched this cycle; IR and instr_pc keep their old contents.
            if (redirect || stop) begin
                ir_d    = ir_q;
                ipc_d   = ipc_q;
                valid_d = 1'b0;
                pc_d    = redirect ? redirPc : pc_q;
            end
            if (stop) begin
                state_d = HALT;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            ipc_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            ipc_q   <= ipc_d;
            valid_q <= valid_d;
        end
    end

`ifdef FETCH_CALL_STACK_EN
    // The return address is the word after the CALL itself, not the discarded fetch.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            fault_q <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_q[i] <= '0;
            end
        end else begin
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
            if (push) begin
                stack_q[cnt_q[PTR_W-1:0]] <= ipc_q + ADDR_W'(1);
            end
        end
    end

    assign stack_fault = fault_q;
    assign stack_count = cnt_q;
`else
    assign stack_fault = 1'b0;
    assign stack_count = '0;
`endif

    assign imem_addr   = pc_q;
    assign instruction = ir_q;
    assign instr_valid = valid_q;
    assign instr_pc    = ipc_q;
    assign halted      = (state_q == HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: scoreboard of expected per-cycle fetch state.
// Expectations follow the FETCH_CALL_STACK_EN setting of the build.
module tb_fetch_unit;

    localparam logic [2:0] INC  = 3'd0;
    localparam logic [2:0] JUMP = 3'd1;
    localparam logic [2:0] BR   = 3'd2;
    localparam logic [2:0] CALL = 3'd3;
    localparam logic [2:0] RET  = 3'd4;
    localparam logic [2:0] HLT  = 3'd5;

`ifdef FETCH_CALL_STACK_EN
    localparam bit HAS_STACK = 1'b1;
`else
    localparam bit HAS_STACK = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        stall;
    logic [2:0]  pc_control;
    logic        branch_taken;
    logic [15:0] jump_target;
    logic [15:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] instruction;
    logic        instr_valid;
    logic [15:0] instr_pc;
    logic        halted;
    logic        stack_fault;
    logic [1:0]  stack_count;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] tgt;
        logic        tk;
        logic        stl;
        logic [68:0] ev;
        string       nm;
    } stim_t;

    typedef struct {
        logic [68:0] ev;
        string       nm;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;

    fetch_unit #(.ADDR_W(16), .STACK_DEPTH(2), .RESET_PC(16'h0000)) dut (
        .clock(clock), .reset(reset), .stall(stall), .pc_control(pc_control),
        .branch_taken(branch_taken), .jump_target(jump_target), .imem_addr(imem_addr),
        .imem_data(imem_data), .instruction(instruction), .instr_valid(instr_valid),
        .instr_pc(instr_pc), .halted(halted), .stack_fault(stack_fault),
        .stack_count(stack_count)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] rom(input logic [15:0] a);
        return {16'hA5C3, a};
    endfunction

    assign imem_data = rom(imem_addr);

    // Expected vector: {halted, fault, count, valid, pc, instr_pc, instruction}; the word fields read 0 when not valid.
    function automatic logic [68:0] mk(input logic h, input logic f, input logic [1:0] c,
                                       input logic v, input logic [15:0] pc, input logic [15:0] ipc);
        return {h, f, c, v, pc, (v ? ipc : 16'h0), (v ? rom(ipc) : 32'h0)};
    endfunction

    function automatic logic [68:0] obs();
        return {halted, stack_fault, stack_count, instr_valid, imem_addr,
                (instr_valid ? instr_pc : 16'h0), (instr_valid ? instruction : 32'h0)};
    endfunction

    function automatic stim_t st(input logic [2:0] op, input logic [15:0] tgt, input logic tk,
                                 input logic stl, input logic [68:0] ev, input string nm);
        stim_t s;
        s.op = op; s.tgt = tgt; s.tk = tk; s.stl = stl; s.ev = ev; s.nm = nm;
        return s;
    endfunction

    task automatic drive(input stim_t s);
        pc_control   = s.op;
        jump_target  = s.tgt;
        branch_taken = s.tk;
        stall        = s.stl;
        expQ.push_back('{s.ev, s.nm});
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic doReset();
        @(negedge clock);
        reset = 1'b1; stall = 1'b0; pc_control = INC; branch_taken = 1'b0; jump_target = '0;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [68:0] want;
        reset = 1'b1; stall = 1'b0; pc_control = INC; branch_taken = 1'b0; jump_target = '0;
        want = mk(0, 0, 0, 0, 16'h0, 16'h0);
        #1;
        checks++;
        if (obs() !== want) begin
            errors++;
            $display("[TB] FAIL reset_async: got %h want %h", obs(), want);
        end
        @(negedge clock);
        checks++;
        if (obs() !== want) begin
            errors++;
            $display("[TB] FAIL reset_held: got %h want %h", obs(), want);
        end
        reset = 1'b0;
    endtask

    task automatic test_inc_sequence();
        stim_t s[$];
        exp_t  e;
        doReset();
        for (int i = 0; i < 4; i++) begin
            s.push_back(st(INC, 0, 0, 0, mk(0, 0, 0, 1, 16'(i + 1), 16'(i)), $sformatf("inc_%0d", i)));
        end
        foreach (s[i]) begin
            drive(s[i]);
            e = expQ.pop_front();
            checks++;
            if (obs() !== e.ev) begin
                errors++;
                $display("[TB] FAIL %s: got %h want %h", e.nm, obs(), e.ev);
            end
        end
    endtask

    task automatic test_jump();
        stim_t s[$];
        exp_t  e;
        doReset();
        s.push_back(st(INC,  0,       0, 0, mk(0, 0, 0, 1, 16'h1, 16'h0),       "jmp_pre0"));
        s.push_back(st(INC,  0,       0, 0, mk(0, 0, 0, 1, 16'h2, 16'h1),       "jmp_pre1"));
        s.push_back(st(INC,  0,       0, 0, mk(0, 0, 0, 1, 16'h3, 16'h2),       "jmp_pre2"));
        s.push_back(st(JUMP, 16'h40,  0, 0, mk(0, 0, 0, 0, 16'h40, 16'h0),      "jmp_bubble"));
        s.push_back(st(INC,  0,       0, 0, mk(0, 0, 0, 1, 16'h41, 16'h40),     "jmp_landed"));
        s.push_back(st(INC,  0,       0, 0, mk(0, 0, 0, 1, 16'h42, 16'h41),     "jmp_next"));
        s.push_back(st(JUMP, 16'hFFFF, 0, 0, mk(0, 0, 0, 0, 16'hFFFF, 16'h0),   "jmp_top"));
        s.push_back(st(INC,  0,       0, 0, mk(0, 0, 0, 1, 16'h0, 16'hFFFF),    "pc_wrap"));
        s.push_back(st(INC,  0,       0, 0, mk(0, 0, 0, 1, 16'h1, 16'h0),       "pc_after_wrap"));
        foreach (s[i]) begin
            drive(s[i]);
            e = expQ.pop_front();
            checks++;
            if (obs() !== e.ev) begin
                errors++;
                $display("[TB] FAIL %s: got %h want %h", e.nm, obs(), e.ev);
            end
        end
    endtask

    task automatic test_branch();
        stim_t s[$];
        exp_t  e;
        for (int pass = 0; pass < 2; pass++) begin
            s.delete();
            doReset();
            for (int i = 0; i < 6; i++) begin
                s.push_back(st(INC, 0, 0, 0, mk(0, 0, 0, 1, 16'(i + 1), 16'(i)), "br_pre"));
            end
            if (pass == 0) begin
                s.push_back(st(BR, 16'h10, 0, 0, mk(0, 0, 0, 1, 16'h7, 16'h6), "br_not_taken"));
            end else begin
                s.push_back(st(BR,  16'h10, 1, 0, mk(0, 0, 0, 0, 16'h10, 16'h0), "br_taken_bubble"));
                s.push_back(st(INC, 0,      0, 0, mk(0, 0, 0, 1, 16'h11, 16'h10), "br_taken_landed"));
            end
            foreach (s[i]) begin
                drive(s[i]);
                e = expQ.pop_front();
                checks++;
                if (obs() !== e.ev) begin
                    errors++;
                    $display("[TB] FAIL %s: got %h want %h", e.nm, obs(), e.ev);
                end
            end
        end
    endtask

    task automatic test_call_ret();
        stim_t s[$];
        exp_t  e;
        logic [1:0] c1;
        c1 = HAS_STACK ? 2'd1 : 2'd0;
        doReset();
        for (int i = 0; i < 4; i++) begin
            s.push_back(st(INC, 0, 0, 0, mk(0, 0, 0, 1, 16'(i + 1), 16'(i)), "call_pre"));
        end
        s.push_back(st(CALL, 16'h20, 0, 0, mk(0, 0, c1, 0, 16'h20, 16'h0),  "call_bubble"));
        s.push_back(st(INC,  0,      0, 0, mk(0, 0, c1, 1, 16'h21, 16'h20), "call_landed"));
        s.push_back(st(INC,  0,      0, 0, mk(0, 0, c1, 1, 16'h22, 16'h21), "call_body"));
        s.push_back(st(RET,  0,      0, 0, HAS_STACK ? mk(0, 0, 0, 0, 16'h4, 16'h0)
                                                     : mk(1, 0, 0, 0, 16'h22, 16'h0), "ret_bubble"));
        s.push_back(st(INC,  0,      0, 0, HAS_STACK ? mk(0, 0, 0, 1, 16'h5, 16'h4)
                                                     : mk(1, 0, 0, 0, 16'h22, 16'h0), "ret_resume"));
        foreach (s[i]) begin
            drive(s[i]);
            e = expQ.pop_front();
            checks++;
            if (obs() !== e.ev) begin
                errors++;
                $display("[TB] FAIL %s: got %h want %h", e.nm, obs(), e.ev);
            end
        end
    endtask

    task automatic test_stack_limits();
        stim_t s[$];
        exp_t  e;
        logic [68:0] ovf;
        ovf = mk(1, 1, 2'd2, 0, 16'h21, 16'h0);
        doReset();
        s.push_back(st(INC,  0,      0, 0, mk(0, 0, 0, 1, 16'h1, 16'h0), "nest_pre"));
        s.push_back(st(CALL, 16'h10, 0, 0, mk(0, 0, HAS_STACK ? 2'd1 : 2'd0, 0, 16'h10, 16'h0),  "nest_call1"));
        s.push_back(st(INC,  0,      0, 0, mk(0, 0, HAS_STACK ? 2'd1 : 2'd0, 1, 16'h11, 16'h10), "nest_body1"));
        s.push_back(st(CALL, 16'h20, 0, 0, mk(0, 0, HAS_STACK ? 2'd2 : 2'd0, 0, 16'h20, 16'h0),  "nest_call2"));
        s.push_back(st(INC,  0,      0, 0, mk(0, 0, HAS_STACK ? 2'd2 : 2'd0, 1, 16'h21, 16'h20), "nest_body2"));
        s.push_back(st(CALL, 16'h30, 0, 0, HAS_STACK ? ovf : mk(0, 0, 0, 0, 16'h30, 16'h0), "overflow"));
        s.push_back(st(INC,  0,      0, 1, HAS_STACK ? ovf : mk(0, 0, 0, 0, 16'h30, 16'h0), "halt_stall"));
        s.push_back(st(JUMP, 16'h50, 0, 0, HAS_STACK ? ovf : mk(0, 0, 0, 1, 16'h31, 16'h30), "halt_sticky"));
        foreach (s[i]) begin
            drive(s[i]);
            e = expQ.pop_front();
            checks++;
            if (obs() !== e.ev) begin
                errors++;
                $display("[TB] FAIL %s: got %h want %h", e.nm, obs(), e.ev);
            end
        end
        s.delete();
        doReset();
        s.push_back(st(INC, 0, 0, 0, mk(0, 0, 0, 1, 16'h1, 16'h0), "under_pre"));
        s.push_back(st(RET, 0, 0, 0, mk(1, HAS_STACK, 0, 0, 16'h1, 16'h0), "underflow"));
        s.push_back(st(INC, 0, 0, 0, mk(1, HAS_STACK, 0, 0, 16'h1, 16'h0), "underflow_hold"));
        foreach (s[i]) begin
            drive(s[i]);
            e = expQ.pop_front();
            checks++;
            if (obs() !== e.ev) begin
                errors++;
                $display("[TB] FAIL %s: got %h want %h", e.nm, obs(), e.ev);
            end
        end
    endtask

    task automatic test_halt_alias();
        stim_t s[$];
        exp_t  e;
        doReset();
        s.push_back(st(INC,  0,      0, 0, mk(0, 0, 0, 1, 16'h1, 16'h0), "alias_pre"));
        s.push_back(st(3'd7, 16'h40, 0, 0, mk(0, 0, 0, 1, 16'h2, 16'h1), "alias_op7"));
        s.push_back(st(3'd6, 16'h40, 0, 0, mk(0, 0, 0, 1, 16'h3, 16'h2), "alias_op6"));
        s.push_back(st(HLT,  0,      0, 0, mk(1, 0, 0, 0, 16'h3, 16'h0), "hlt"));
        s.push_back(st(INC,  0,      0, 0, mk(1, 0, 0, 0, 16'h3, 16'h0), "hlt_frozen"));
        s.push_back(st(JUMP, 16'h40, 0, 1, mk(1, 0, 0, 0, 16'h3, 16'h0), "hlt_ignores"));
        foreach (s[i]) begin
            drive(s[i]);
            e = expQ.pop_front();
            checks++;
            if (obs() !== e.ev) begin
                errors++;
                $display("[TB] FAIL %s: got %h want %h", e.nm, obs(), e.ev);
            end
        end
    endtask

    task automatic test_stall();
        stim_t s[$];
        exp_t  e;
        logic [68:0] want;
        doReset();
        s.push_back(st(INC, 0, 0, 0, mk(0, 0, 0, 1, 16'h1, 16'h0), "stall_pre0"));
        s.push_back(st(INC, 0, 0, 0, mk(0, 0, 0, 1, 16'h2, 16'h1), "stall_pre1"));
        for (int i = 0; i < 3; i++) begin
            s.push_back(st(JUMP, 16'h40, 0, 1, mk(0, 0, 0, 1, 16'h2, 16'h1), $sformatf("stall_hold%0d", i)));
        end
        s.push_back(st(JUMP, 16'h40, 0, 0, mk(0, 0, 0, 0, 16'h40, 16'h0),  "stall_release"));
        s.push_back(st(INC,  0,      0, 0, mk(0, 0, 0, 1, 16'h41, 16'h40), "stall_landed"));
        s.push_back(st(INC,  0,      0, 1, mk(0, 0, 0, 1, 16'h41, 16'h40), "stall_again"));
        foreach (s[i]) begin
            drive(s[i]);
            e = expQ.pop_front();
            checks++;
            if (obs() !== e.ev) begin
                errors++;
                $display("[TB] FAIL %s: got %h want %h", e.nm, obs(), e.ev);
            end
        end
        want = mk(0, 0, 0, 0, 16'h0, 16'h0);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (obs() !== want) begin
            errors++;
            $display("[TB] FAIL reset_mid_stall: got %h want %h", obs(), want);
        end
        #1 reset = 1'b0;
        stall = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        $display("[TB] fetch_unit bench start, stack build = %0d", HAS_STACK);
        test_reset();
        test_inc_sequence();
        test_jump();
        test_branch();
        test_call_ret();
        test_stack_limits();
        test_halt_alias();
        test_stall();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
